// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
//   SA_WIDTH    - default operand width
//   sa_state_e  - controller state encoding (idle / run / done)
`timescale 1ns / 1ps

package serial_adder_pkg;

  localparam int unsigned SA_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit combinational full adder.
//   x, y  - operand bits
//   ci    - carry in
//   s     - sum bit   (x ^ y ^ ci)
//   co    - carry out (majority of x, y, ci)
`timescale 1ns / 1ps

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one bit per clock through a single
// full-adder cell and a carry flop.
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - begin an addition (accepted in idle or done)
//   a, b   - operands, captured on an accepted start
//   cin    - carry in, captured on an accepted start
//   busy   - high while bits are processed
//   done   - one-cycle pulse, sum/cout valid
//   sum    - N-bit result, held until overwritten by the next addition
//   cout   - final carry, held with sum
`timescale 1ns / 1ps

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = SA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

  sa_state_e       state_q, state_d;
  logic [N-1:0]    sh_a_q, sh_a_d;
  logic [N-1:0]    sh_b_q, sh_b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  // The only combinational path from the shift registers to the carry flop.
  fa_cell u_fa_cell (
    .x  (sh_a_q[0]),
    .y  (sh_b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        // start is deliberately not looked at here: the running addition is never disturbed.
        sum_d   = {fa_s, sum_q[N-1:1]};
        carry_d = fa_co;
        sh_a_d  = {1'b0, sh_a_q[N-1:1]};
        sh_b_d  = {1'b0, sh_b_q[N-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          cout_d  = fa_co;
          state_d = StDone;
        end
      end

      StDone: begin
        // Back-to-back accept keeps throughput at one addition per N+1 cycles.
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns / 1ps

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [15:0] a_in, b_in;
  logic        cin_in;

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a_in[7:0]),
    .b     (b_in[7:0]),
    .cin   (cin_in),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.N(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a_in),
    .b     (b_in),
    .cin   (cin_in),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic obs_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic [15:0] obs_sum(input int w);
    return (w == 8) ? {8'h00, sum8} : sum16;
  endfunction

  function automatic logic obs_cout(input int w);
    return (w == 8) ? cout8 : cout16;
  endfunction

  task automatic start_sel(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start16 = v;
  endtask

  // Launch one addition, then wait for done checking latency, busy length and result.
  // With noise set, random start pulses and operand changes are driven while running.
  task automatic do_add(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec,
                        input bit noise, input string tag);
    int lat;
    int busy_n;
    start_sel(w, 1'b1);
    a_in   = av;
    b_in   = bv;
    cin_in = cv;
    tick();
    start_sel(w, 1'b0);
    lat    = 1;
    busy_n = 0;
    while (!obs_done(w) && lat < 3 * w) begin
      if (obs_busy(w)) busy_n++;
      if (noise) begin
        start_sel(w, 1'($urandom_range(0, 1)));
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        cin_in = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    start_sel(w, 1'b0);
    check_val({tag, "_latency"}, lat, w + 1);
    check_val({tag, "_busy_cycles"}, busy_n, w);
    check_val({tag, "_sum"}, obs_sum(w), es);
    check_val({tag, "_cout"}, obs_cout(w), ec);
  endtask

  task automatic abort_run(input int w, input int k);
    int n_done;
    start_sel(w, 1'b1);
    a_in   = 16'($urandom);
    b_in   = 16'($urandom);
    cin_in = 1'($urandom_range(0, 1));
    tick();
    start_sel(w, 1'b0);
    repeat (k) tick();
    rst = 1'b1;
    #1;
    check_val("abort_busy", obs_busy(w), 0);
    check_val("abort_done", obs_done(w), 0);
    check_val("abort_sum", obs_sum(w), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_done = 0;
    repeat (w + 3) begin
      if (obs_done(w)) n_done++;
      tick();
    end
    check_val("abort_no_done", n_done, 0);
  endtask

  initial begin
    logic [7:0]  cap_sum;
    logic        cap_cout;
    int          n_done;
    int          got;
    int          t_done[2];
    logic [7:0]  s_b2b[2];
    logic        c_b2b[2];
    logic [16:0] full;
    logic [15:0] av, bv, es;
    logic        cv;

    rst     = 1'b1;
    start8  = 1'b0;
    start16 = 1'b0;
    a_in    = '0;
    b_in    = '0;
    cin_in  = 1'b0;
    cap_sum = '0;
    cap_cout = 1'b0;
    t_done  = '{0, 0};
    s_b2b   = '{8'h00, 8'h00};
    c_b2b   = '{1'b0, 1'b0};

    repeat (2) tick();
    check_val("rst_busy", busy8, 0);
    check_val("rst_done", done8, 0);
    check_val("rst_sum", sum8, 0);
    check_val("rst_cout", cout8, 0);
    check_val("rst_busy16", busy16, 0);
    check_val("rst_sum16", sum16, 0);
    rst = 1'b0;
    tick();

    // Basic addition.
    do_add(8, 16'h35, 16'h4A, 1'b0, 16'h7F, 1'b0, 1'b0, "t1");
    tick();
    check_val("t1_done_one_cycle", done8, 0);

    // start pulsed mid-run must be ignored.
    start8 = 1'b1; a_in = 16'h10; b_in = 16'h20; cin_in = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    start8 = 1'b1; a_in = 16'hAA; b_in = 16'h55; cin_in = 1'b1;
    tick();
    start8 = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (done8) begin
        n_done++;
        cap_sum  = sum8;
        cap_cout = cout8;
      end
      tick();
    end
    check_val("t3_done_count", n_done, 1);
    check_val("t3_sum", cap_sum, 8'h30);
    check_val("t3_cout", cap_cout, 0);

    // Carry propagation and full-carry boundaries.
    do_add(8, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, "t2a");
    tick();
    do_add(8, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, 1'b0, "t2b");
    repeat (3) tick();
    check_val("t2_hold_sum", sum8, 8'hFF);
    check_val("t2_hold_cout", cout8, 1);

    // Reset mid-run discards the partial result.
    start8 = 1'b1; a_in = 16'h0F; b_in = 16'h01; cin_in = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_val("t4_busy", busy8, 0);
    check_val("t4_done", done8, 0);
    check_val("t4_sum", sum8, 0);
    check_val("t4_cout", cout8, 0);
    tick();
    rst = 1'b0;
    n_done = 0;
    repeat (12) begin
      if (done8) n_done++;
      tick();
    end
    check_val("t4_no_done", n_done, 0);
    do_add(8, 16'h0F, 16'h01, 1'b0, 16'h10, 1'b0, 1'b0, "t4_fresh");
    tick();

    // start held high: back-to-back additions.
    start8 = 1'b1; a_in = 16'h01; b_in = 16'h01; cin_in = 1'b0;
    tick();
    a_in = 16'h80; b_in = 16'h80;
    got = 0;
    for (int t = 0; t < 30 && got < 2; t++) begin
      if (done8) begin
        t_done[got] = t;
        s_b2b[got]  = sum8;
        c_b2b[got]  = cout8;
        got++;
      end
      if (got < 2) tick();
    end
    start8 = 1'b0;
    check_val("t5_done_count", got, 2);
    check_val("t5_first_done", t_done[0], 8);
    check_val("t5_spacing", t_done[1] - t_done[0], 9);
    check_val("t5_sum0", s_b2b[0], 8'h02);
    check_val("t5_cout0", c_b2b[0], 0);
    check_val("t5_sum1", s_b2b[1], 8'h00);
    check_val("t5_cout1", c_b2b[1], 1);
    repeat (2) tick();
    check_val("t5_idle", busy8, 0);

    // Random sweep against the reference model, both widths.
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 8 : 16;
      for (int it = 0; it < 600; it++) begin
        if ($urandom_range(0, 15) == 0) begin
          abort_run(w, $urandom_range(1, w - 1));
        end else begin
          repeat ($urandom_range(0, 2)) tick();
          av = 16'($urandom);
          bv = 16'($urandom);
          cv = 1'($urandom_range(0, 1));
          if (w == 8) begin
            av = av & 16'h00FF;
            bv = bv & 16'h00FF;
          end
          full = {1'b0, av} + {1'b0, bv} + {16'h0, cv};
          es   = (w == 8) ? (full[15:0] & 16'h00FF) : full[15:0];
          do_add(w, av, bv, cv, es, full[w], 1'b1, "rnd");
        end
      end
      repeat (2) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
